// File: rtl/neurocore_pkg.sv
// Shared neurocore types, default sizing and the saturating adder used by the update datapaths.
package neurocore_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned DefNNeurons  = 8;
  localparam int unsigned DefW         = 8;
  localparam int unsigned DefLeakShift = 1;
  localparam int unsigned DefRefrac    = 1;

  // Widest operand sat_add supports; callers zero-extend into it and slice the result back.
  localparam int unsigned SatMaxW = 16;

  function automatic logic [SatMaxW-1:0] sat_add(input logic [SatMaxW-1:0] a,
                                                 input logic [SatMaxW-1:0] b,
                                                 input int unsigned        w);
    logic [SatMaxW:0] sum;
    logic [SatMaxW:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = {(SatMaxW + 1){1'b1}} >> (SatMaxW + 1 - w);
    if (sum > lim) begin
      return lim[SatMaxW-1:0];
    end
    return sum[SatMaxW-1:0];
  endfunction

endpackage

// File: rtl/lif_step_scheduler_if.sv
// Input-current stream from the deserialiser into the LIF scheduler (valid/ready).
interface lif_step_scheduler_if #(
  parameter int unsigned W = 8
);
  logic         cur_valid;
  logic [W-1:0] cur;
  logic         cur_ready;

  modport master (output cur_valid, output cur, input cur_ready);
  modport slave  (input cur_valid, input cur, output cur_ready);
endinterface

// File: rtl/lif_update.sv
// Combinational LIF neuron update: leak, saturating integrate, threshold and refractory hold.
module lif_update
  import neurocore_pkg::*;
#(
  parameter int unsigned W          = DefW,
  parameter int unsigned LEAK_SHIFT = DefLeakShift
) (
  input  logic [W-1:0] v,
  input  logic [W-1:0] cur,
  input  logic [W-1:0] thr,
  input  logic         refrac_active,
  output logic [W-1:0] v_next,
  output logic         spike
);

  logic [W-1:0]       lv;
  logic [SatMaxW-1:0] s_wide;
  logic [W-1:0]       s;
  logic               unused_s_hi;

  assign lv          = v - (v >> LEAK_SHIFT);
  assign s_wide      = sat_add(SatMaxW'(lv), SatMaxW'(cur), W);
  assign s           = s_wide[W-1:0];
  assign unused_s_hi = ^s_wide[SatMaxW-1:W];

  always_comb begin
    v_next = s;
    spike  = 1'b0;
    if (refrac_active) begin
      v_next = '0;
    end else if (s >= thr) begin
      v_next = '0;
      spike  = 1'b1;
    end
  end

endmodule

// File: rtl/lif_step_scheduler.sv
// Streams one current per neuron through a shared lif_update per timestep and publishes
// the resulting spike vector; owns the membrane/refractory register file and the FSM.
module lif_step_scheduler
  import neurocore_pkg::*;
#(
  parameter int unsigned N_NEURONS  = DefNNeurons,
  parameter int unsigned W          = DefW,
  parameter int unsigned LEAK_SHIFT = DefLeakShift,
  parameter int unsigned REFRAC     = DefRefrac
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         tick_i,
  input  logic [W-1:0]                 threshold_i,
  lif_step_scheduler_if.slave          cur_if,
  output logic [N_NEURONS-1:0]         spike_o,
  output logic                         done_o,
  output logic                         busy_o,
  input  logic [$clog2(N_NEURONS)-1:0] mem_sel_i,
  output logic [W-1:0]                 mem_o
);

  localparam int unsigned IW = $clog2(N_NEURONS);
  localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [W-1:0]         thr_q, thr_d;
  logic [N_NEURONS-1:0] acc_q, acc_d;
  logic [N_NEURONS-1:0] spike_q, spike_d;
  logic [W-1:0]         mem_q    [N_NEURONS];
  logic [W-1:0]         mem_d    [N_NEURONS];
  logic [RW-1:0]        refrac_q [N_NEURONS];
  logic [RW-1:0]        refrac_d [N_NEURONS];

  logic         hs;
  logic         refrac_active;
  logic [W-1:0] v_next;
  logic         upd_spike;

  // Ready depends only on registered state and ena, never on cur_valid.
  assign cur_if.cur_ready = (state_q == StRun) && ena;
  assign hs               = cur_if.cur_valid && cur_if.cur_ready;
  assign refrac_active    = (refrac_q[idx_q] != '0);

  lif_update #(
    .W         (W),
    .LEAK_SHIFT(LEAK_SHIFT)
  ) u_update (
    .v            (mem_q[idx_q]),
    .cur          (cur_if.cur),
    .thr          (thr_q),
    .refrac_active(refrac_active),
    .v_next       (v_next),
    .spike        (upd_spike)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    thr_d    = thr_q;
    acc_d    = acc_q;
    spike_d  = spike_q;
    mem_d    = mem_q;
    refrac_d = refrac_q;
    unique case (state_q)
      StIdle: begin
        if (tick_i && ena) begin
          state_d = StRun;
          idx_d   = '0;
          acc_d   = '0;
          thr_d   = threshold_i;
        end
      end
      StRun: begin
        if (hs) begin
          mem_d[idx_q] = v_next;
          if (refrac_active) begin
            refrac_d[idx_q] = refrac_q[idx_q] - RW'(1);
          end else if (upd_spike) begin
            refrac_d[idx_q] = RW'(REFRAC);
            acc_d[idx_q]    = 1'b1;
          end
          if (idx_q == IW'(N_NEURONS - 1)) begin
            state_d = StDone;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      StDone: begin
        // Completes regardless of ena so a stalled host never loses a finished step.
        spike_d = acc_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      thr_q    <= '0;
      acc_q    <= '0;
      spike_q  <= '0;
      mem_q    <= '{default: '0};
      refrac_q <= '{default: '0};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      thr_q    <= thr_d;
      acc_q    <= acc_d;
      spike_q  <= spike_d;
      mem_q    <= mem_d;
      refrac_q <= refrac_d;
    end
  end

  assign spike_o = spike_q;
  assign done_o  = (state_q == StDone);
  assign busy_o  = (state_q != StIdle);
  assign mem_o   = (32'(mem_sel_i) < N_NEURONS) ? mem_q[mem_sel_i] : '0;

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Self-checking bench for lif_step_scheduler against an integer LIF reference model.
module tb_lif_step_scheduler;
  localparam int unsigned N = 8;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         tick_i;
  logic [W-1:0] threshold_i;
  logic [N-1:0] spike_o;
  logic         done_o;
  logic         busy_o;
  logic [2:0]   mem_sel_i;
  logic [W-1:0] mem_o;

  lif_step_scheduler_if #(.W(W)) cur_if ();

  lif_step_scheduler #(
    .N_NEURONS (N),
    .W         (W),
    .LEAK_SHIFT(1),
    .REFRAC    (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .tick_i     (tick_i),
    .threshold_i(threshold_i),
    .cur_if     (cur_if),
    .spike_o    (spike_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .mem_sel_i  (mem_sel_i),
    .mem_o      (mem_o)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  // Reference state: membrane and refractory count per neuron, last published spikes.
  int           mv [N];
  int           mr [N];
  logic [N-1:0] exp_spike;
  int           curs [N];

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      mr[i] = 0;
    end
    exp_spike = '0;
  endfunction

  function automatic bit model_update(int i, int cur, int thr);
    int s;
    if (mr[i] > 0) begin
      mr[i] = mr[i] - 1;
      mv[i] = 0;
      return 1'b0;
    end
    s = mv[i] - mv[i] / 2 + cur;
    if (s > 255) s = 255;
    if (s >= thr) begin
      mv[i] = 0;
      mr[i] = 1;
      return 1'b1;
    end
    mv[i] = s;
    return 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ena = 1'b0; tick_i = 1'b0; cur_if.cur_valid = 1'b0; cur_if.cur = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // One timestep: tick, stream curs[] with valid at valid_pct %, optional 5-cycle ena stall
  // after 3 handshakes and an extra tick pulse mid-run. Returns cycle of done_o after tick.
  task automatic run_step(input int thr, input int valid_pct, input bit stall,
                          input bit extra_tick, output logic [N-1:0] spk, output int done_cyc);
    int           h, cyc, stall_left;
    bit           stalled, ticked, v, e;
    logic [N-1:0] exp_acc;
    @(negedge clk);
    tick_i = 1'b1; threshold_i = W'(thr); ena = 1'b1; cur_if.cur_valid = 1'b0;
    @(posedge clk);
    h = 0; cyc = 0; stall_left = 0; stalled = 0; ticked = 0; exp_acc = '0; done_cyc = -1;
    spk = 'x;
    while (h < N && cyc < 300) begin
      @(negedge clk);
      cyc++;
      tick_i = 1'b0;
      if (stall && !stalled && h == 3) begin
        stall_left = 5;
        stalled = 1;
      end
      e = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      v = ($urandom_range(99) < valid_pct);
      if (extra_tick && !ticked && h == 5) begin
        tick_i = 1'b1;
        ticked = 1;
      end
      ena = e; cur_if.cur_valid = v; cur_if.cur = W'(curs[h]);
      if (h > 0) mem_sel_i = 3'(h - 1);
      #1;
      if (h > 0) begin
        tests_run++;
        if (mem_o !== W'(mv[h-1])) begin
          fails++;
          $display("FAIL mem_after_hs[%0d]: got %0d want %0d", h - 1, mem_o, mv[h-1]);
        end
      end
      tests_run++;
      if (cur_if.cur_ready !== e) begin
        fails++;
        $display("FAIL ready_run: got %b want %b (hs %0d)", cur_if.cur_ready, e, h);
      end
      tests_run++;
      if (done_o !== 1'b0 || busy_o !== 1'b1 || spike_o !== exp_spike) begin
        fails++;
        $display("FAIL run_status: done %b busy %b spike %h want 0 1 %h",
                 done_o, busy_o, spike_o, exp_spike);
      end
      if (v && e) begin
        if (model_update(h, curs[h], thr)) exp_acc[h] = 1'b1;
        h++;
      end
      @(posedge clk);
    end
    if (h < N) begin
      tests_run++;
      fails++;
      $display("FAIL step_timeout: got %0d handshakes want %0d", h, N);
      return;
    end
    @(negedge clk);
    cyc++;
    cur_if.cur_valid = 1'b0; ena = 1'b1; tick_i = 1'b0;
    #1;
    tests_run++;
    if (done_o !== 1'b1 || cur_if.cur_ready !== 1'b0 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL done_pulse: done %b ready %b busy %b want 1 0 1",
               done_o, cur_if.cur_ready, busy_o);
    end
    done_cyc = cyc;
    @(negedge clk);
    #1;
    tests_run++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_done: done %b busy %b want 0 0", done_o, busy_o);
    end
    tests_run++;
    if (spike_o !== exp_acc) begin
      fails++;
      $display("FAIL spike_model: got %h want %h", spike_o, exp_acc);
    end
    exp_spike = exp_acc;
    spk = spike_o;
    for (int i = 0; i < N; i++) begin
      mem_sel_i = 3'(i);
      #1;
      tests_run++;
      if (mem_o !== W'(mv[i])) begin
        fails++;
        $display("FAIL mem_final[%0d]: got %0d want %0d", i, mem_o, mv[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ena = 1'($urandom); tick_i = 1'($urandom); threshold_i = W'($urandom);
      cur_if.cur_valid = 1'($urandom); cur_if.cur = W'($urandom);
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (spike_o !== '0 || done_o !== 1'b0 || busy_o !== 1'b0 || cur_if.cur_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: spike %h done %b busy %b ready %b want 0",
               spike_o, done_o, busy_o, cur_if.cur_ready);
    end
    for (int i = 0; i < N; i++) begin
      mem_sel_i = 3'(i);
      #1;
      tests_run++;
      if (mem_o !== '0) begin
        fails++;
        $display("FAIL reset_mem[%0d]: got %0d want 0", i, mem_o);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b0; tick_i = 1'b0; cur_if.cur_valid = 1'b0;
    model_clear();
  endtask

  task automatic test_integrate();
    logic [N-1:0] spk;
    int           dc;
    logic [N-1:0] exp_spk [3] = '{8'h00, 8'h00, 8'hFF};
    int           exp_v   [3] = '{60, 90, 0};
    do_reset();
    for (int i = 0; i < N; i++) curs[i] = 60;
    for (int s = 0; s < 3; s++) begin
      run_step(100, 100, 1'b0, 1'b0, spk, dc);
      tests_run++;
      if (spk !== exp_spk[s]) begin
        fails++;
        $display("FAIL integ_spike[%0d]: got %h want %h", s, spk, exp_spk[s]);
      end
      mem_sel_i = 3'(s);
      #1;
      tests_run++;
      if (mem_o !== W'(exp_v[s])) begin
        fails++;
        $display("FAIL integ_mem[%0d]: got %0d want %0d", s, mem_o, exp_v[s]);
      end
      tests_run++;
      if (dc !== N + 1) begin
        fails++;
        $display("FAIL integ_latency[%0d]: got %0d want %0d", s, dc, N + 1);
      end
    end
  endtask

  task automatic test_saturate();
    logic [N-1:0] spk;
    int           dc;
    logic [N-1:0] exp_spk [2] = '{8'h00, 8'h01};
    int           exp_v   [2] = '{200, 0};
    do_reset();
    for (int i = 0; i < N; i++) curs[i] = 0;
    curs[0] = 200;
    for (int s = 0; s < 2; s++) begin
      run_step(255, 100, 1'b0, 1'b0, spk, dc);
      mem_sel_i = 3'd0;
      #1;
      tests_run++;
      if (spk !== exp_spk[s] || mem_o !== W'(exp_v[s])) begin
        fails++;
        $display("FAIL saturate[%0d]: spike %h v %0d want %h %0d",
                 s, spk, mem_o, exp_spk[s], exp_v[s]);
      end
    end
  endtask

  task automatic test_refractory();
    logic [N-1:0] spk;
    int           dc;
    logic         exp_s [3] = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < N; i++) curs[i] = 0;
    curs[3] = 200;
    for (int s = 0; s < 3; s++) begin
      run_step(100, 100, 1'b0, 1'b0, spk, dc);
      mem_sel_i = 3'd3;
      #1;
      tests_run++;
      if (spk[3] !== exp_s[s] || mem_o !== '0 || dc !== N + 1) begin
        fails++;
        $display("FAIL refractory[%0d]: spike3 %b v %0d done_cyc %0d want %b 0 %0d",
                 s, spk[3], mem_o, dc, exp_s[s], N + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] spk;
    int           dc;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < N; i++) curs[i] = int'($urandom_range(255));
      run_step(int'($urandom_range(200, 50)), 50, 1'b1, 1'b1, spk, dc);
      tests_run++;
      if (dc < N + 6) begin
        fails++;
        $display("FAIL bp_latency[%0d]: got %0d want >= %0d", s, dc, N + 6);
      end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        #1;
        tests_run++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || spike_o !== exp_spike) begin
          fails++;
          $display("FAIL bp_no_requeue: busy %b done %b spike %h want 0 0 %h",
                   busy_o, done_o, spike_o, exp_spike);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] spk;
    int           dc;
    do_reset();
    for (int i = 0; i < N; i++) curs[i] = (i < 4) ? 200 : 60;
    run_step(100, 100, 1'b0, 1'b0, spk, dc);
    tests_run++;
    if (spk !== 8'h0F) begin
      fails++;
      $display("FAIL midrst_setup: got %h want 0f", spk);
    end
    @(negedge clk);
    tick_i = 1'b1; threshold_i = 8'd255; ena = 1'b1; cur_if.cur_valid = 1'b1;
    cur_if.cur = 8'd50;
    @(negedge clk);
    tick_i = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (spike_o !== '0 || done_o !== 1'b0 || busy_o !== 1'b0 || cur_if.cur_ready !== 1'b0) begin
      fails++;
      $display("FAIL midrst_outputs: spike %h done %b busy %b ready %b want 0",
               spike_o, done_o, busy_o, cur_if.cur_ready);
    end
    for (int i = 0; i < N; i++) begin
      mem_sel_i = 3'(i);
      #1;
      tests_run++;
      if (mem_o !== '0) begin
        fails++;
        $display("FAIL midrst_mem[%0d]: got %0d want 0", i, mem_o);
      end
    end
    @(negedge clk);
    cur_if.cur_valid = 1'b0;
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < N; i++) curs[i] = 200;
    run_step(100, 100, 1'b0, 1'b0, spk, dc);
    tests_run++;
    if (spk !== 8'hFF || dc !== N + 1) begin
      fails++;
      $display("FAIL midrst_fresh: spike %h done_cyc %0d want ff %0d", spk, dc, N + 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; tick_i = 1'b0; threshold_i = '0; mem_sel_i = '0;
    cur_if.cur_valid = 1'b0; cur_if.cur = '0;
    model_clear();
    test_reset();
    test_integrate();
    test_saturate();
    test_refractory();
    test_backpressure();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/lif_step_scheduler.md
# lif_step_scheduler

Sequences one timestep of the neurocore's leaky-integrate-and-fire (LIF) array through a single shared update datapath. Each neuron's membrane potential lives in an internal register file. On each timestep the block streams one input current per neuron through the datapath in index order and applies leak, integrate, saturate, threshold and refractory rules. It publishes the resulting spike vector. It sits between the chip's input deserialiser (the current source) and the `uo_out` spike/readout mux in `tt_um_neurocore`.

## Interface
Parameters:
- `N_NEURONS`, 8: neurons in the array; index width `IW = $clog2(N_NEURONS)`.
- `W`, 8: membrane and current width, unsigned.
- `LEAK_SHIFT`, 1: leak per timestep is `v >> LEAK_SHIFT`.
- `REFRAC`, 1: timesteps a neuron is held after spiking; width `RW = $clog2(REFRAC+1)`.

Ports (one clock; reset asynchronous, active-low):
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  global enable; low stalls the FSM and forces `cur_ready_o` low.
- `tick_i`  in  1  start a timestep; sampled only in IDLE.
- `threshold_i`  in  W  firing threshold; latched on an accepted tick.
- `cur_valid_i`  in  1  input current valid.
- `cur_i`  in  W  current for neuron `idx`, in index order 0..N-1.
- `cur_ready_o`  out  1  current accepted when `cur_valid_i && cur_ready_o`.
- `spike_o`  out  N_NEURONS  spike vector of the last completed timestep, registered.
- `done_o`  out  1  one-cycle pulse when `spike_o` updates.
- `busy_o`  out  1  high in RUN and DONE.
- `mem_sel_i`  in  IW  debug select.
- `mem_o`  out  W  membrane potential of neuron `mem_sel_i` (combinational read).

## Operation
- States:
  - IDLE: on `tick_i && ena`, latch the threshold, clear `idx` and `spike_acc`, go to RUN.
  - RUN: on each handshake, update neuron `idx` and increment `idx`. The handshake at `idx == N-1` goes to DONE.
  - DONE: `spike_o <= spike_acc`, `done_o = 1`, go to IDLE.
- Update (shared datapath, one neuron per handshake):
  - Leaked value: `lv = v - (v >> LEAK_SHIFT)`.
  - Sum: `s = lv + cur`, computed W+1 bits wide, saturating to `2^W-1`.
- If `refrac[idx] != 0`: v stays 0, no spike, `refrac[idx]` decrements, and the current is still consumed.
- Else if `s >= thr`: set `spike_acc[idx]`, v is reset to 0, and `refrac[idx]` is set to REFRAC. `thr == 0` therefore fires every non-refractory neuron.
- Else: `v <= s`.
- `tick_i` in RUN or DONE is ignored and not queued. `cur_valid_i` outside RUN is ignored.
- `ena` low in RUN: no handshake, and `idx` and all state hold. In DONE the DONE→IDLE step still completes.
- Reset values (any time, including mid-run): state IDLE, `idx` 0, all membranes 0, all refractory counters 0, `spike_o` 0, `done_o` 0, `busy_o` 0, `cur_ready_o` 0.

## Timing
- `cur_ready_o = (state == RUN) && ena`, registered-state derived, with no combinational path from `cur_valid_i`.
- Tick accepted at edge 0 → RUN from cycle 1. With `valid` held high, handshakes occur in cycles 1..N, DONE and `done_o` in cycle N+1, and IDLE in cycle N+2.
- Minimum tick-to-done is N+1 cycles. A new tick can be accepted in cycle N+2.
- `spike_o` changes only on the DONE edge and is held until the next DONE or reset.
- A membrane write is visible on `mem_o` the cycle after its handshake.

## Structure
- `neurocore_pkg`:
  - FSM state enum `{IDLE, RUN, DONE}`.
  - Default constants for W, N_NEURONS, LEAK_SHIFT, REFRAC.
  - A `sat_add` function shared with the other neurocore blocks.
- Sub-module `lif_update`: combinational leak, saturating add and threshold compare. Inputs `v`, `cur`, `thr`, `refrac_active`; outputs `v_next`, `spike`. The scheduler owns the register file, the counters and the FSM.

## Test plan
All scenarios use N=8, W=8, LEAK_SHIFT=1, REFRAC=1.
1. Reset with random inputs: `spike_o`=0, `done_o`=0, `busy_o`=0, `cur_ready_o`=0, `mem_o`=0 for all selects.
2. thr=100, all currents 60, valid held high, three timesteps:
   - `mem_o` = 60, then 90, then 0.
   - `spike_o` = 0x00, 0x00, 0xFF.
   - `done_o` exactly N+1 cycles after each tick.
3. thr=255, neuron 0 fed 200 twice: step 1 v=200, no spike. Step 2: 100+200 saturates to 255 ≥ 255, so `spike_o[0]`=1 and v=0.
4. Refractory, thr=100, neuron 3 fed 200 on each of three steps: spike, then hold (v=0, no spike, current consumed), then spike. `spike_o[3]` = 1, 0, 1.
5. Backpressure, ena and ignored tick:
   - Stimulus: `cur_valid_i` random at 50%, `ena` low for 5 cycles mid-RUN, `tick_i` pulsed during RUN.
   - Response: exactly 8 handshakes, `done_o` once, currents applied to the correct indices, and the extra tick does not start a second step.
6. `rst_n` asserted after 3 handshakes: all outputs and membranes go to 0 immediately. After release, a fresh tick runs a full 8-handshake step normally.
